alu_seq_unit: RTL and testbench

Parametrised, handshaked successor to the 8-bit combinational ALU/save path of the CPU. It executes the same eight operations (add, sub, and, or, xor, mul, div, compare) on WIDTH-bit operands, runs mul/div iteratively over WIDTH cycles, and holds each result under backpressure. Results can optionally be written into a DEPTH-entry circular result store with a combinational read port. It sits between the decode stage and the register/writeback logic.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/iter_muldiv.sv | 80 ++++++++
 rtl/alu_seq_unit.sv | 154 +++++++++++++++
 tb/tb_alu_seq_unit.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential ALU slice.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_MUL = 3'b101,
    OP_DIV = 3'b110,
    OP_CMP = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Bit positions of the compare outcome inside the result word.
  localparam int CMP_LT = 0;
  localparam int CMP_EQ = 1;
  localparam int CMP_GT = 2;

  // Operations that run through the multi-cycle datapath.
  function automatic logic is_iterative(op_e op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/iter_muldiv.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle.
// hi/lo share registers: mul keeps {partial product, multiplier},
// div keeps {remainder, dividend/quotient}.
module iter_muldiv #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    cnt;
  logic             div_r;
  logic [WIDTH-1:0] opnd_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   trial;

  // Next value of the hi/lo pair after one iteration.
  // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    step_hi = hi_r;
    step_lo = lo_r;
    sum     = '0;
    trial   = '0;
    if (div_r) begin
      trial = {hi_r, lo_r[WIDTH-1]};
      if (trial >= {1'b0, opnd_r}) begin
        trial   = trial - {1'b0, opnd_r};
        step_lo = {lo_r[WIDTH-2:0], 1'b1};
      end else begin
        step_lo = {lo_r[WIDTH-2:0], 1'b0};
      end
      step_hi = trial[WIDTH-1:0];
    end else begin
      sum     = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opnd_r} : '0);
      step_hi = sum[WIDTH:1];
      step_lo = {sum[0], lo_r[WIDTH-1:1]};
    end
  end

  // Load operands on start, then step once per cycle until the counter drains.
  // NOTE: state registers use non-blocking assignment so all flops update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      div_r  <= 1'b0;
      opnd_r <= '0;
      hi_r   <= '0;
      lo_r   <= '0;
    end else if (start) begin
      cnt    <= CW'(WIDTH);
      div_r  <= is_div;
      opnd_r <= is_div ? b : a;
      hi_r   <= '0;
      lo_r   <= is_div ? a : b;
    end else if (cnt != '0) begin
      cnt  <= cnt - 1'b1;
      hi_r <= step_hi;
      lo_r <= step_lo;
    end
  end

  // The final step is in progress: its outcome is visible on hi/lo now.
  assign done = (cnt == CW'(1));
  assign lo   = step_lo;
  assign hi   = step_hi;

endmodule

// File: rtl/alu_seq_unit.sv
// Handshaked ALU: single-cycle logic/arith ops, iterative mul/div,
// results held until consumed, optional circular result store.
module alu_seq_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               opcode,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  input  logic                     save,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         result,
  output logic [WIDTH-1:0]         result_hi,
  output logic                     carry_out,
  output logic                     zero,
  output logic                     div_zero,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   mem_count
);

  localparam int AW = $clog2(DEPTH);

  state_e           state;
  op_e              op_in;
  op_e              op_r;
  logic [WIDTH-1:0] b_r;
  logic             save_r;
  logic [WIDTH:0]   sum_w;
  logic [WIDTH:0]   diff_w;
  logic [WIDTH-1:0] s_result;
  logic             s_carry;
  logic             md_start;
  logic             md_done;
  logic [WIDTH-1:0] md_lo;
  logic [WIDTH-1:0] md_hi;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic             wr_en;

  assign op_in     = op_e'(opcode);
  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign md_start  = in_ready && in_valid && is_iterative(op_in);

  iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (md_start),
    .is_div  (op_in == OP_DIV),
    .a       (a),
    .b       (b),
    .done    (md_done),
    .lo      (md_lo),
    .hi      (md_hi)
  );

  // Single-cycle results straight from the request operands.
  always_comb begin
    sum_w    = {1'b0, a} + {1'b0, b};
    diff_w   = {1'b0, a} - {1'b0, b};
    s_result = '0;
    s_carry  = 1'b0;
    case (op_in)
      OP_ADD: begin s_result = sum_w[WIDTH-1:0];  s_carry = sum_w[WIDTH];  end
      OP_SUB: begin s_result = diff_w[WIDTH-1:0]; s_carry = diff_w[WIDTH]; end
      OP_AND: s_result = a & b;
      OP_OR:  s_result = a | b;
      OP_XOR: s_result = a ^ b;
      OP_CMP: begin
        s_result[CMP_LT] = (a < b);
        s_result[CMP_EQ] = (a == b);
        s_result[CMP_GT] = (a > b);
        s_carry          = (a < b);
      end
      default: ;
    endcase
  end

  // Control FSM with registered result and flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      op_r      <= OP_ADD;
      b_r       <= '0;
      save_r    <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      carry_out <= 1'b0;
      zero      <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            op_r   <= op_in;
            b_r    <= b;
            save_r <= save;
            if (is_iterative(op_in)) begin
              state <= ST_BUSY;
            end else begin
              result    <= s_result;
              result_hi <= '0;
              carry_out <= s_carry;
              zero      <= (s_result == '0);
              div_zero  <= 1'b0;
              state     <= ST_DONE;
            end
          end
        end
        ST_BUSY: begin
          if (md_done) begin
            result    <= md_lo;
            result_hi <= md_hi;
            carry_out <= (op_r == OP_MUL) && (md_hi != '0);
            zero      <= (md_lo == '0);
            div_zero  <= (op_r == OP_DIV) && (b_r == '0);
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign wr_en = (state == ST_DONE) && out_ready && save_r;

  // Circular result store, written on the consuming handshake.
  // NOTE: the store is cleared on reset, so it is built from flops rather than a RAM macro.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr    <= '0;
      mem_count <= '0;
    end else if (wr_en) begin
      mem[wr_ptr] <= result;
      wr_ptr      <= wr_ptr + 1'b1;
      if (mem_count != (AW+1)'(DEPTH)) mem_count <= mem_count + 1'b1;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: tb/tb_alu_seq_unit.sv
// Self-checking bench for alu_seq_unit: directed cases from hand arithmetic
// plus randomized ops against a behavioural model and a store model.
module tb_alu_seq_unit;
  import alu_pkg::*;

  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH);

  typedef struct packed {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         c;
    logic         z;
    logic         dz;
  } exp_t;

  logic          clk;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    opcode;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          save;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic [W-1:0]  result_hi;
  logic          carry_out;
  logic          zero;
  logic          div_zero;
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  rd_data;
  logic [AW:0]   mem_count;

  int checks   = 0;
  int failures = 0;

  exp_t         exp_cur;
  logic         pending;
  logic [W-1:0] exp_mem [DEPTH];
  int           exp_ptr;
  int           exp_count;
  logic         rd_manual;

  alu_seq_unit #(.WIDTH(W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .a         (a),
    .b         (b),
    .save      (save),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_hi (result_hi),
    .carry_out (carry_out),
    .zero      (zero),
    .div_zero  (div_zero),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .mem_count (mem_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic finish_tb();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  // Behavioural reference: plain integer arithmetic on the operands.
  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    longint unsigned ux, uy, m, full;
    exp_t e;
    ux = x; uy = y; m = (64'd1 << W) - 1;
    e = '0;
    case (op)
      OP_ADD: begin full = ux + uy; e.res = W'(full); e.c = (full > m); end
      OP_SUB: begin e.res = W'(ux - uy); e.c = (ux < uy); end
      OP_AND: e.res = x & y;
      OP_OR:  e.res = x | y;
      OP_XOR: e.res = x ^ y;
      OP_MUL: begin full = ux * uy; e.res = W'(full); e.hi = W'(full >> W); e.c = (e.hi != 0); end
      OP_DIV: begin
        if (uy == 0) begin e.res = W'(m); e.hi = x; e.dz = 1'b1; end
        else begin e.res = W'(ux / uy); e.hi = W'(ux % uy); end
      end
      default: begin
        e.res = (ux < uy) ? W'(1) : (ux == uy) ? W'(2) : W'(4);
        e.c   = (ux < uy);
      end
    endcase
    e.z = (e.res == 0);
    return e;
  endfunction

  // Random read address for the continuous store comparison.
  initial begin
    rd_addr = '0;
    forever begin
      @(negedge clk);
      if (!rd_manual) rd_addr = AW'($urandom_range(0, DEPTH-1));
    end
  end

  // Compare process: outputs against the model whenever they are meaningful.
  always @(posedge clk) begin
    #2;
    if (out_valid === 1'b1) begin
      check("valid_without_request", pending, 1'b1);
      check("result", result, exp_cur.res);
      check("result_hi", result_hi, exp_cur.hi);
      check("carry_out", carry_out, exp_cur.c);
      check("zero", zero, exp_cur.z);
      check("div_zero", div_zero, exp_cur.dz);
    end
    check("mem_count", mem_count, exp_count);
    check("rd_data", rd_data, exp_mem[rd_addr]);
  end

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
    exp_ptr   = 0;
    exp_count = 0;
    pending   = 1'b0;
    exp_cur   = '0;
  endtask

  // One transaction: request, wait for the result (poking the idle inputs meanwhile),
  // optionally stall the consumer, then hand the result over.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic sv, input int stall,
                        output logic [W-1:0] r_res, output logic [W-1:0] r_hi,
                        output logic r_c, output logic r_z, output logic r_dz, output int lat);
    int exp_lat;
    exp_cur   = model(op, x, y);
    exp_lat   = (op == OP_MUL || op == OP_DIV) ? W + 1 : 1;
    pending   = 1'b1;
    in_valid  = 1'b1;
    opcode    = op;
    a         = x;
    b         = y;
    save      = sv;
    out_ready = 1'($urandom_range(0, 1));
    check("in_ready_idle", in_ready, 1'b1);
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
      check("in_ready_busy", in_ready, 1'b0);
      in_valid  = 1'($urandom_range(0, 1));
      opcode    = 3'($urandom_range(0, 7));
      a         = W'($urandom);
      b         = W'($urandom);
      save      = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
    end while (lat < 40);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    if (!out_valid) begin
      check("out_valid_timeout", out_valid, 1'b1);
      finish_tb();
    end
    check("latency", lat, exp_lat);
    r_res = result; r_hi = result_hi; r_c = carry_out; r_z = zero; r_dz = div_zero;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_valid", out_valid, 1'b1);
      check("stall_result", result, r_res);
      check("stall_hi", result_hi, r_hi);
    end
    out_ready = 1'b1;
    @(posedge clk);
    if (sv) begin
      exp_mem[exp_ptr] = exp_cur.res;
      exp_ptr   = (exp_ptr + 1) % DEPTH;
      exp_count = (exp_count < DEPTH) ? exp_count + 1 : DEPTH;
    end
    pending = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    check("idle_after_handshake", out_valid, 1'b0);
  endtask

  logic [W-1:0] r_res, r_hi;
  logic         r_c, r_z, r_dz;
  int           lat;
  logic [W-1:0] mem_lit [DEPTH];

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    opcode    = '0;
    a         = '0;
    b         = '0;
    save      = 1'b0;
    out_ready = 1'b0;
    rd_manual = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_result", {result_hi, result}, 16'h0);
    check("rst_flags", {carry_out, zero, div_zero}, 3'b000);
    check("rst_mem_count", mem_count, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Directed cases with hand-computed values.
    run_op(OP_ADD, 8'h05, 8'h03, 1'b0, 0, r_res, r_hi, r_c, r_z, r_dz, lat);
    check("add_result", r_res, 8'h08);
    check("add_carry", r_c, 1'b0);
    check("add_latency", lat, 1);
    run_op(OP_SUB, 8'hCC, 8'hAA, 1'b0, 0, r_res, r_hi, r_c, r_z, r_dz, lat);
    check("sub_result", r_res, 8'h22);
    check("sub_carry", r_c, 1'b0);
    run_op(OP_MUL, 8'hCC, 8'hAA, 1'b0, 0, r_res, r_hi, r_c, r_z, r_dz, lat);
    check("mul_result", r_res, 8'h78);
    check("mul_hi", r_hi, 8'h87);
    check("mul_carry", r_c, 1'b1);
    check("mul_latency", lat, 9);
    run_op(OP_DIV, 8'h05, 8'h03, 1'b0, 0, r_res, r_hi, r_c, r_z, r_dz, lat);
    check("div_result", r_res, 8'h01);
    check("div_rem", r_hi, 8'h02);
    run_op(OP_DIV, 8'h05, 8'h00, 1'b0, 0, r_res, r_hi, r_c, r_z, r_dz, lat);
    check("div0_result", r_res, 8'hFF);
    check("div0_hi", r_hi, 8'h05);
    check("div0_flag", r_dz, 1'b1);
    check("div0_latency", lat, 9);
    run_op(OP_CMP, 8'hCC, 8'hAA, 1'b0, 0, r_res, r_hi, r_c, r_z, r_dz, lat);
    check("cmp_result", r_res, 8'h04);
    check("cmp_carry", r_c, 1'b0);
    run_op(OP_AND, 8'h05, 8'h03, 1'b0, 0, r_res, r_hi, r_c, r_z, r_dz, lat);
    check("and_result", r_res, 8'h01);
    check("and_zero", r_z, 1'b0);
    run_op(OP_XOR, 8'h05, 8'h05, 1'b0, 0, r_res, r_hi, r_c, r_z, r_dz, lat);
    check("xor_result", r_res, 8'h00);
    check("xor_zero", r_z, 1'b1);
    check("store_empty", mem_count, 0);

    // Five saved adds into a four-entry store: the fifth overwrites entry 0.
    for (int i = 0; i < 5; i++)
      run_op(OP_ADD, W'(i), 8'h01, 1'b1, 0, r_res, r_hi, r_c, r_z, r_dz, lat);
    mem_lit[0] = 8'h05; mem_lit[1] = 8'h02; mem_lit[2] = 8'h03; mem_lit[3] = 8'h04;
    run_op(OP_OR, 8'h30, 8'h0C, 1'b0, 5, r_res, r_hi, r_c, r_z, r_dz, lat);
    check("or_stalled_result", r_res, 8'h3C);
    rd_manual = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      rd_addr = AW'(i);
      #1;
      check("store_entry", rd_data, mem_lit[i]);
    end
    check("store_count", mem_count, 4);
    rd_manual = 1'b0;

    // Randomized traffic, biased toward zero divisors and equal operands.
    for (int n = 0; n < 150; n++) begin
      logic [2:0]   op;
      logic [W-1:0] x, y;
      op = 3'($urandom_range(0, 7));
      x  = W'($urandom);
      y  = W'($urandom);
      if ($urandom_range(0, 7) == 0) y = '0;
      if ($urandom_range(0, 7) == 0) y = x;
      run_op(op, x, y, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
             r_res, r_hi, r_c, r_z, r_dz, lat);
    end

    // Reset in the middle of a multiply discards it and clears the store.
    if (exp_count == 0)
      run_op(OP_ADD, 8'h07, 8'h00, 1'b1, 0, r_res, r_hi, r_c, r_z, r_dz, lat);
    exp_cur  = model(OP_MUL, 8'h0F, 8'h0F);
    pending  = 1'b1;
    in_valid = 1'b1;
    opcode   = OP_MUL;
    a        = 8'h0F;
    b        = 8'h0F;
    save     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    model_reset();
    #1;
    check("midrst_in_ready", in_ready, 1'b1);
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_mem_count", mem_count, 0);
    check("midrst_result", {result_hi, result}, 16'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_out_valid", out_valid, 1'b0);
    run_op(OP_ADD, 8'h01, 8'h01, 1'b0, 0, r_res, r_hi, r_c, r_z, r_dz, lat);
    check("post_rst_add", r_res, 8'h02);

    finish_tb();
  end

endmodule
